// File: rtl/complex_mult_pkg.sv
// Shared types and width rules for the complex accumulator: FSM encoding and
// the minimum accumulator width that keeps a full 256-product frame from overflowing.
package complex_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } acc_state_e;

    // log2(256) guard bits absorb the growth of the longest frame.
    localparam int ACC_GUARD_BITS = 8;

    function automatic int acc_min_width(input int data_width);
        return 2 * data_width + ACC_GUARD_BITS;
    endfunction

endpackage

// File: rtl/complex_acc_lane.sv
// One accumulator lane: sign-extends a signed product and either loads it,
// adds it to the held sum, or clears the sum.
module complex_acc_lane
    import complex_mult_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = acc_min_width(DATA_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    load_i,
    input  logic                    add_i,
    input  logic [2*DATA_WIDTH-1:0] prod_i,
    output logic [ACC_WIDTH-1:0]    acc_o
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;

    assign prod_ext = {{(ACC_WIDTH - PW){prod_i[PW-1]}}, prod_i};

    // Clear wins over load, load wins over add; otherwise the sum is held.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (load_i) begin
            acc_d = prod_ext;
        end else if (add_i) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/complex_acc.sv
// Frame accumulator for complex products: sums acc_len products per frame and
// presents the sum downstream with a valid/ready handshake.
module complex_acc
    import complex_mult_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = acc_min_width(DATA_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sw_rst,
    input  logic [7:0]              acc_len,
    input  logic                    res_val,
    input  logic [2*DATA_WIDTH-1:0] result_re,
    input  logic [2*DATA_WIDTH-1:0] result_im,
    output logic                    res_ready,
    output logic                    acc_val,
    output logic [ACC_WIDTH-1:0]    acc_re,
    output logic [ACC_WIDTH-1:0]    acc_im,
    input  logic                    acc_ready,
    output logic [15:0]             frame_cnt,
    output logic [1:0]              dbg_state_o
);

    if (ACC_WIDTH < acc_min_width(DATA_WIDTH)) begin : g_width_check
        $error("complex_acc: ACC_WIDTH below 2*DATA_WIDTH+8 can overflow");
    end

    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both high. res_ready and acc_val are registers that depend only on
    // FSM state, so neither side sees a combinational path through this block.

    acc_state_e  state_q;
    logic [8:0]  cnt_q;
    logic [8:0]  cnt_d;
    logic [8:0]  len_q;
    logic [8:0]  len_d;
    logic        acc_val_q;
    logic        res_ready_q;
    logic [15:0] frame_cnt_q;

    logic prod_hs;
    logic sum_hs;
    logic lane_clr;
    logic lane_load;
    logic lane_add;

    assign prod_hs = res_val && res_ready_q;
    assign sum_hs  = acc_val_q && acc_ready;

    // acc_len of zero encodes a 256-product frame.
    assign len_d = (acc_len == 8'd0) ? 9'd256 : {1'b0, acc_len};
    assign cnt_d = cnt_q + 9'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            acc_val_q   <= 1'b0;
            res_ready_q <= 1'b0;
            frame_cnt_q <= '0;
        end else if (sw_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_val_q   <= 1'b0;
            res_ready_q <= 1'b1;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    res_ready_q <= 1'b1;
                    if (prod_hs) begin
                        len_q <= len_d;
                        cnt_q <= 9'd1;
                        if (len_d == 9'd1) begin
                            state_q     <= ST_OUTPUT;
                            acc_val_q   <= 1'b1;
                            res_ready_q <= 1'b0;
                        end else begin
                            state_q <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    res_ready_q <= 1'b1;
                    if (prod_hs) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == len_q) begin
                            state_q     <= ST_OUTPUT;
                            acc_val_q   <= 1'b1;
                            res_ready_q <= 1'b0;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (sum_hs) begin
                        state_q     <= ST_IDLE;
                        cnt_q       <= '0;
                        acc_val_q   <= 1'b0;
                        res_ready_q <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    acc_val_q   <= 1'b0;
                    res_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // The sum registers keep the finished sum after acceptance; only the next
    // frame's first product (or a clear) replaces it.
    assign lane_clr  = sw_rst;
    assign lane_load = !sw_rst && prod_hs && (state_q == ST_IDLE);
    assign lane_add  = !sw_rst && prod_hs && (state_q == ST_ACCUM);

    complex_acc_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane_re (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (lane_clr),
        .load_i (lane_load),
        .add_i  (lane_add),
        .prod_i (result_re),
        .acc_o  (acc_re)
    );

    complex_acc_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane_im (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (lane_clr),
        .load_i (lane_load),
        .add_i  (lane_add),
        .prod_i (result_im),
        .acc_o  (acc_im)
    );

    assign res_ready   = res_ready_q;
    assign acc_val     = acc_val_q;
    assign frame_cnt   = frame_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/complex_acc.md
COMPLEX_ACC -- requirements
Module: complex_acc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the multiplier operand width; the upstream product width is 2*DATA_WIDTH.
REQ-002 SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH+8, giving the sum width; it is not overridable below that value.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1 bit; asynchronous, active-high reset.
REQ-005 SHALL have port sw_rst, input, 1 bit; synchronous soft clear.
REQ-006 SHALL have port acc_len, input, 8 bits; number of products per sum, where 0 means 256.
REQ-007 SHALL have port res_val, input, 1 bit; upstream product valid.
REQ-008 SHALL have ports result_re and result_im, inputs, 2*DATA_WIDTH bits each; signed two's-complement product.
REQ-009 SHALL have port res_ready, output, 1 bit; product accepted when res_val and res_ready are both high.
REQ-010 SHALL have port acc_val, output, 1 bit; sum valid.
REQ-011 SHALL have ports acc_re and acc_im, outputs, ACC_WIDTH bits each; signed sums.
REQ-012 SHALL have port acc_ready, input, 1 bit; sum accepted when acc_val and acc_ready are both high.
REQ-013 SHALL have port frame_cnt, output, 16 bits; count of sums accepted downstream, wrapping at 65535 to 0.

Function
REQ-014 SHALL implement FSM states IDLE (no partial sum), ACCUM (partial sum held) and OUTPUT (sum pending).
REQ-015 SHALL drive res_ready high in IDLE and ACCUM and low in OUTPUT; res_ready depends on state only, never combinationally on acc_ready.
REQ-016 SHALL, on a product handshake in IDLE, latch acc_len into len_q, load the sign-extended product into the sum registers (no add of the old value) and set count to 1.
REQ-017 SHALL, on a product handshake in ACCUM, add the sign-extended product to the sum registers and increment count.
REQ-018 SHALL transition to OUTPUT on the handshake that makes count equal len_q (len_q=1 goes IDLE->OUTPUT directly); acc_val rises the next cycle with the sum including that product.
REQ-019 SHALL ignore changes on acc_len while in ACCUM or OUTPUT.
REQ-020 SHALL, in OUTPUT, hold acc_val high with acc_re and acc_im stable until acc_ready; on that handshake go to IDLE, drop acc_val and increment frame_cnt.
REQ-021 SHALL retain acc_re and acc_im after acceptance until the next frame's first product is loaded.
REQ-022 SHALL never overflow: 256 products of magnitude up to 2^(2*DATA_WIDTH-1) fit in ACC_WIDTH.
REQ-023 SHALL give sw_rst priority over any handshake in the same cycle: go to IDLE, clear count, acc_val, acc_re, acc_im and frame_cnt, and not accept the concurrent product or sum.
REQ-024 SHALL track a 9-bit count so that len_q=256 terminates correctly without wrap.

Reset
REQ-025 SHALL, while rst is high, immediately force state IDLE, count 0, len_q 0, acc_val 0, acc_re 0, acc_im 0, frame_cnt 0 and res_ready 0.
REQ-026 SHALL raise res_ready on the first clock edge after rst deasserts, discarding any frame that was in progress.

Structure
REQ-027 SHALL place the FSM state encoding and ACC_WIDTH derivation in the shared package complex_mult_pkg.
REQ-028 SHALL instantiate one sub-module, complex_acc_lane (sign-extend plus load-or-add register), twice: once for re, once for im.

Verification
REQ-029 SHALL cover: acc_len=4, products (1,2),(3,-4),(-5,6),(7,8), acc_ready=1 -> acc_re=6, acc_im=12, acc_val high for one cycle starting the cycle after the 4th handshake, frame_cnt=1.
REQ-030 SHALL cover: acc_len=1, res_val held high with (10,-10) -> every product is output as (10,-10), and res_ready is low one cycle per product.
REQ-031 SHALL cover: a pending sum with acc_ready low for 5 cycles -> acc_val stays high, values stay stable, res_ready stays low; acceptance occurs on the 6th cycle.
REQ-032 SHALL cover: acc_len=0, with 256 products of (-32768,-32768) at DATA_WIDTH=8 -> acc_re = acc_im = -8388608 and no wrap.
REQ-033 SHALL cover: acc_len=4, sw_rst pulsed after 2 products (simultaneous with res_val) -> the partial sum is discarded; the next 4 products of (1,1) yield (4,4).
REQ-034 SHALL cover: rst asserted mid-frame between clock edges -> all outputs are 0 before the next edge, and the following frame sums correctly.
